// File: rtl/aes_dec_arbiter.sv
// ---------------------------------------------------------------------------
// aes_dec_arbiter
//
// Shares one AES decipher engine between two requesters.  A job (ciphertext
// block + key length) is accepted from one requester at a time.  The job is
// latched, started on the engine with a single eng_next pulse, and the
// engine's result is held on that requester's response port until it is
// taken.  A requester that waits while the engine is busy is served later,
// and jobs from one requester are never dropped or reordered.
//
// When both requesters are valid in the same cycle, the one that was not
// served last wins.  After reset, requester 0 wins the first conflict.
//
// Optional feature (compile-time macro AES_DEC_ARBITER_TIMEOUT_EN):
//   Adds an 8-bit watchdog on the WAIT state.  If the engine does not report
//   ready within TIMEOUT_CYCLES cycles, the job completes with rspN_err=1 and
//   an all-zero result block.  Without the macro there is no watchdog,
//   rspN_err is always 0 and WAIT lasts until the engine is ready.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in WAIT cycles (watchdog build only)
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   reqN_valid     requester N has a job                          (N = 0,1)
//   reqN_ready     job from requester N is accepted this cycle
//   reqN_block     requester N ciphertext block
//   reqN_keylen    requester N key length (0 = AES-128, 1 = AES-256)
//   rspN_valid     result for requester N is available
//   rspN_ready     requester N takes the result
//   rspN_block     plaintext for requester N (0 when not valid)
//   rspN_err       result for requester N is invalid (watchdog expired)
//   eng_next       one-cycle start pulse to the engine
//   eng_keylen     key length of the job presented to the engine
//   eng_block      block of the job presented to the engine
//   eng_ready      engine idle / done flag
//   eng_new_block  engine result
// ---------------------------------------------------------------------------
module aes_dec_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req0_keylen,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         req1_keylen,

  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_block,
  output logic         rsp0_err,

  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_block,
  output logic         rsp1_err,

  output logic         eng_next,
  output logic         eng_keylen,
  output logic [127:0] eng_block,
  input  logic         eng_ready,
  input  logic [127:0] eng_new_block
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         grantIdx_q, grantIdx_d;
  logic         lastGrant_q, lastGrant_d;
  logic [127:0] jobBlock_q, jobBlock_d;
  logic         jobKeylen_q, jobKeylen_d;
  logic [127:0] result_q, result_d;

`ifdef AES_DEC_ARBITER_TIMEOUT_EN
  logic         respErr_q, respErr_d;
  logic [7:0]   wdCount_q, wdCount_d;
  logic [7:0]   wdCountInc;
`else
  // The limit only matters when the watchdog is built in.
  logic         unusedTimeoutParam;
  assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
`endif

  logic         selIdx;
  logic         canGrant;
  logic         accept;
  logic         rspHandshake;

  // Arbitration: a lone valid requester is chosen directly; on a conflict the
  // requester that was not served last wins.  Grants are only offered in IDLE
  // while the engine reports ready, so a job is never accepted that the engine
  // could not start.
  always_comb begin
    selIdx = 1'b0;
    if (req0_valid && req1_valid) begin
      selIdx = ~lastGrant_q;
    end else begin
      selIdx = req1_valid;
    end
  end

  assign canGrant   = (state_q == ST_IDLE) && eng_ready;
  assign req0_ready = canGrant && req0_valid && !selIdx;
  assign req1_ready = canGrant && req1_valid && selIdx;
  assign accept     = req0_ready || req1_ready;

  assign rspHandshake = (state_q == ST_RESP) &&
                        (grantIdx_q ? rsp1_ready : rsp0_ready);

`ifdef AES_DEC_ARBITER_TIMEOUT_EN
  assign wdCountInc = wdCount_q + 8'd1;
`endif

  // Next-state logic for the job FSM.  The latched job stays on the engine
  // inputs from ISSUE until the next job is accepted.  Last-grant only moves
  // when the response is taken, so a stalled response keeps its priority
  // position.
  always_comb begin
    state_d     = state_q;
    grantIdx_d  = grantIdx_q;
    lastGrant_d = lastGrant_q;
    jobBlock_d  = jobBlock_q;
    jobKeylen_d = jobKeylen_q;
    result_d    = result_q;
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
    respErr_d   = respErr_q;
    wdCount_d   = wdCount_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grantIdx_d  = selIdx;
          jobBlock_d  = selIdx ? req1_block  : req0_block;
          jobKeylen_d = selIdx ? req1_keylen : req0_keylen;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
        wdCount_d = 8'd0;
`endif
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (eng_ready) begin
          result_d = eng_new_block;
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
          respErr_d = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
        else begin
          wdCount_d = wdCountInc;
          if (wdCountInc == TIMEOUT_CYCLES) begin
            result_d  = '0;
            respErr_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
`endif
      end

      ST_RESP: begin
        if (rspHandshake) begin
          lastGrant_d = grantIdx_q;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.  Reset abandons any job in flight; last-grant resets to
  // requester 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grantIdx_q  <= 1'b0;
      lastGrant_q <= 1'b1;
      jobBlock_q  <= '0;
      jobKeylen_q <= 1'b0;
      result_q    <= '0;
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
      respErr_q   <= 1'b0;
      wdCount_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      grantIdx_q  <= grantIdx_d;
      lastGrant_q <= lastGrant_d;
      jobBlock_q  <= jobBlock_d;
      jobKeylen_q <= jobKeylen_d;
      result_q    <= result_d;
`ifdef AES_DEC_ARBITER_TIMEOUT_EN
      respErr_q   <= respErr_d;
      wdCount_q   <= wdCount_d;
`endif
    end
  end

  assign eng_next   = (state_q == ST_ISSUE);
  assign eng_block  = jobBlock_q;
  assign eng_keylen = jobKeylen_q;

  // Only the granted requester sees a response; the other port reads zero.
  assign rsp0_valid = (state_q == ST_RESP) && !grantIdx_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  grantIdx_q;
  assign rsp0_block = rsp0_valid ? result_q : '0;
  assign rsp1_block = rsp1_valid ? result_q : '0;

`ifdef AES_DEC_ARBITER_TIMEOUT_EN
  assign rsp0_err = rsp0_valid && respErr_q;
  assign rsp1_err = rsp1_valid && respErr_q;
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_arbiter
//
// Self-checking bench for aes_dec_arbiter.  Directed jobs are queued per
// requester together with their expected responses; a monitor pops and
// compares whenever a response is presented, and checks grant order, engine
// start pulses and latency.  A small engine stand-in maps known ciphertexts
// to plaintexts (the first two entries are the FIPS-197 AES-128 and AES-256
// example vectors; the rest are arbitrary pairs).  Build with
// AES_DEC_ARBITER_TIMEOUT_EN defined to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_aes_dec_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid, req0_ready, req0_keylen;
  logic [127:0] req0_block;
  logic         req1_valid, req1_ready, req1_keylen;
  logic [127:0] req1_block;
  logic         rsp0_valid, rsp0_ready, rsp0_err;
  logic [127:0] rsp0_block;
  logic         rsp1_valid, rsp1_ready, rsp1_err;
  logic [127:0] rsp1_block;
  logic         eng_next, eng_keylen, eng_ready;
  logic [127:0] eng_block, eng_new_block;

  aes_dec_arbiter #(.TIMEOUT_CYCLES(8'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_keylen(req0_keylen),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_keylen(req1_keylen),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_block(rsp0_block), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_block(rsp1_block), .rsp1_err(rsp1_err),
    .eng_next(eng_next), .eng_keylen(eng_keylen), .eng_block(eng_block),
    .eng_ready(eng_ready), .eng_new_block(eng_new_block)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] ctTab [8] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h8ea2b7ca516745bfeafc49904b496089,
    128'h0123456789abcdef0123456789abcdef, 128'h00000000000000000000000000000001,
    128'hffffffffffffffffffffffffffffffff, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5,
    128'h1234567890abcdef1234567890abcdef, 128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c};
  logic klTab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [127:0] ptTab [8] = '{
    128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff,
    128'hfedcba9876543210fedcba9876543210, 128'h80000000000000000000000000000000,
    128'h55555555555555555555555555555555, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
    128'hcafebabedeadbeefcafebabedeadbeef, 128'h13579bdf02468ace13579bdf02468ace};

  typedef struct packed { logic [127:0] blk; logic kl; } job_t;
  typedef struct packed { logic [127:0] blk; logic err; } rsp_t;

  job_t jobQ0[$], jobQ1[$];
  rsp_t expQ0[$], expQ1[$];
  int   grantExpQ[$];

  int total = 0;
  int bad = 0;

  logic holdEngine = 1'b0;
  logic engAbort = 1'b0;
  logic engDoneEvt = 1'b0;
  int   engNextCount = 0;
  int   accCycle [2] = '{0, 0};
  int   rspStart [2] = '{0, 0};
  int   rspHs [2] = '{0, 0};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {127'b0, act}, {127'b0, exp});
  endtask

  // Queues one directed job and its expected response for requester n.
  task automatic applyStimulus(input int n, input int idx, input bit expTimeout);
    job_t j;
    rsp_t r;
    j.blk = ctTab[idx];
    j.kl  = klTab[idx];
    r.blk = expTimeout ? 128'h0 : ptTab[idx];
    r.err = expTimeout;
    if (n == 0) begin
      jobQ0.push_back(j);
      expQ0.push_back(r);
    end else begin
      jobQ1.push_back(j);
      expQ1.push_back(r);
    end
  endtask

  task automatic expectGrant(input int n);
    grantExpQ.push_back(n);
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((jobQ0.size() + jobQ1.size() + expQ0.size() + expQ1.size() + grantExpQ.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    if ((jobQ0.size() + jobQ1.size() + expQ0.size() + expQ1.size() + grantExpQ.size()) != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending items %0d after %0d cycles, want 0",
               jobQ0.size() + jobQ1.size() + expQ0.size() + expQ1.size() + grantExpQ.size(), n);
    end
    tick();
  endtask

  // Holds reset low for two cycles and checks every output is quiet.
  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checkBit("rst_req0_ready", req0_ready, 1'b0);
    checkBit("rst_req1_ready", req1_ready, 1'b0);
    checkBit("rst_rsp0_valid", rsp0_valid, 1'b0);
    checkBit("rst_rsp1_valid", rsp1_valid, 1'b0);
    checkBit("rst_rsp0_err", rsp0_err, 1'b0);
    checkBit("rst_rsp1_err", rsp1_err, 1'b0);
    checkBit("rst_eng_next", eng_next, 1'b0);
    checkBit("rst_eng_keylen", eng_keylen, 1'b0);
    checkOutput("rst_eng_block", eng_block, 128'h0);
    checkOutput("rst_rsp0_block", rsp0_block, 128'h0);
    checkOutput("rst_rsp1_block", rsp1_block, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [127:0] engLookup(input logic [127:0] b, input logic k);
    for (int i = 0; i < 8; i++) begin
      if (ctTab[i] == b && klTab[i] == k) return ptTab[i];
    end
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  // Requester 0 driver: presents the queue head, pops it when accepted.
  initial begin
    req0_valid = 1'b0;
    req0_block = '0;
    req0_keylen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && jobQ0.size() > 0) begin
        req0_valid = 1'b1;
        req0_block = jobQ0[0].blk;
        req0_keylen = jobQ0[0].kl;
      end else begin
        req0_valid = 1'b0;
      end
      #1;
      if (reset_n && req0_valid && req0_ready) void'(jobQ0.pop_front());
    end
  end

  // Requester 1 driver.
  initial begin
    req1_valid = 1'b0;
    req1_block = '0;
    req1_keylen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && jobQ1.size() > 0) begin
        req1_valid = 1'b1;
        req1_block = jobQ1[0].blk;
        req1_keylen = jobQ1[0].kl;
      end else begin
        req1_valid = 1'b0;
      end
      #1;
      if (reset_n && req1_valid && req1_ready) void'(jobQ1.pop_front());
    end
  end

  // Engine stand-in: busy for three cycles after eng_next, then ready with
  // the looked-up plaintext.  holdEngine freezes it; engAbort drops the job.
  initial begin
    logic         engBusy;
    int           engCnt;
    logic [127:0] engBlk;
    logic         engKl;
    engBusy = 1'b0;
    engCnt = 0;
    engBlk = '0;
    engKl = 1'b0;
    eng_ready = 1'b1;
    eng_new_block = '0;
    forever begin
      @(negedge clk);
      engDoneEvt = 1'b0;
      if (!reset_n) begin
        eng_ready = 1'b1;
        engBusy = 1'b0;
      end else if (engAbort) begin
        engAbort = 1'b0;
        engBusy = 1'b0;
        eng_ready = 1'b1;
      end else if (engBusy) begin
        if (!holdEngine) begin
          if (engCnt <= 1) begin
            engBusy = 1'b0;
            eng_ready = 1'b1;
            eng_new_block = engLookup(engBlk, engKl);
            engDoneEvt = 1'b1;
          end else begin
            engCnt--;
          end
        end
      end else if (eng_next) begin
        engBusy = 1'b1;
        eng_ready = 1'b0;
        engCnt = 3;
        engBlk = eng_block;
        engKl = eng_keylen;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic         prevTook, prevDone, took0, took1, wasValid0, wasValid1;
    logic [127:0] expEngBlock;
    logic         expEngKl;
    int           gotIdx;
    prevTook = 1'b0;
    prevDone = 1'b0;
    wasValid0 = 1'b0;
    wasValid1 = 1'b0;
    expEngBlock = '0;
    expEngKl = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prevTook = 1'b0;
        prevDone = 1'b0;
        wasValid0 = 1'b0;
        wasValid1 = 1'b0;
        expEngBlock = '0;
        expEngKl = 1'b0;
      end else begin
        checkBit("eng_next", eng_next, prevTook);
        if (eng_next) engNextCount++;
        checkOutput("eng_block", eng_block, expEngBlock);
        checkBit("eng_keylen", eng_keylen, expEngKl);
        if (prevDone) checkBit("rsp_latency", rsp0_valid | rsp1_valid, 1'b1);
        prevDone = engDoneEvt;

        took0 = req0_valid && req0_ready;
        took1 = req1_valid && req1_ready;
        prevTook = took0 || took1;
        if (took0 || took1) begin
          gotIdx = (took0 && took1) ? 2 : (took1 ? 1 : 0);
          if (grantExpQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL grant_unexpected: got grant %0d want none", gotIdx);
          end else begin
            checkOutput("grant_idx", 128'(gotIdx), 128'(grantExpQ.pop_front()));
          end
          expEngBlock = took1 ? req1_block : req0_block;
          expEngKl = took1 ? req1_keylen : req0_keylen;
          accCycle[took1 ? 1 : 0] = cyc;
        end

        if (rsp0_valid) begin
          if (!wasValid0) rspStart[0] = cyc;
          if (expQ0.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rsp0_unexpected: got %0h want no response", rsp0_block);
          end else begin
            checkOutput("rsp0_block", rsp0_block, expQ0[0].blk);
            checkBit("rsp0_err", rsp0_err, expQ0[0].err);
          end
          checkBit("rsp1_valid_excl", rsp1_valid, 1'b0);
          checkOutput("rsp1_block_zero", rsp1_block, 128'h0);
          if (rsp0_ready) begin
            if (expQ0.size() > 0) void'(expQ0.pop_front());
            rspHs[0] = cyc;
          end
        end
        wasValid0 = rsp0_valid && !rsp0_ready;

        if (rsp1_valid) begin
          if (!wasValid1) rspStart[1] = cyc;
          if (expQ1.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rsp1_unexpected: got %0h want no response", rsp1_block);
          end else begin
            checkOutput("rsp1_block", rsp1_block, expQ1[0].blk);
            checkBit("rsp1_err", rsp1_err, expQ1[0].err);
          end
          checkBit("rsp0_valid_excl", rsp0_valid, 1'b0);
          checkOutput("rsp0_block_zero", rsp0_block, 128'h0);
          if (rsp1_ready) begin
            if (expQ1.size() > 0) void'(expQ1.pop_front());
            rspHs[1] = cyc;
          end
        end
        wasValid1 = rsp1_valid && !rsp1_ready;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed test sequence.
  initial begin
    int n;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    $display("[TB] reset values");
    doReset();

    $display("[TB] single AES-128 job on requester 0");
    engNextCount = 0;
    tick();
    expectGrant(0);
    applyStimulus(0, 0, 1'b0);
    drain(100);
    checkOutput("single_eng_next_pulses", 128'(engNextCount), 128'd1);
    checkOutput("single_latency", 128'(rspStart[0] - accCycle[0]), 128'd5);

    $display("[TB] simultaneous requests after reset");
    doReset();
    tick();
    expectGrant(0);
    expectGrant(1);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(1, 3, 1'b0);
    drain(100);
    checkOutput("b2b_grant_gap", 128'(accCycle[1] - rspHs[0]), 128'd1);

    $display("[TB] fairness over six jobs");
    for (int i = 0; i < 3; i++) begin
      expectGrant(0);
      expectGrant(1);
      applyStimulus(0, 2 * i, 1'b0);
      applyStimulus(1, 2 * i + 1, 1'b0);
    end
    drain(300);

    $display("[TB] response backpressure on requester 1");
    @(negedge clk);
    rsp1_ready = 1'b0;
    tick();
    expectGrant(1);
    applyStimulus(1, 6, 1'b0);
    n = 0;
    while (!rsp1_valid && n < 50) begin
      tick();
      n++;
    end
    checkBit("bp_rsp1_arrives", rsp1_valid, 1'b1);
    expectGrant(0);
    applyStimulus(0, 7, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkBit("bp_rsp1_valid_held", rsp1_valid, 1'b1);
      checkBit("bp_req0_not_granted", req0_ready, 1'b0);
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    drain(100);
    checkOutput("bp_b2b_grant_gap", 128'(accCycle[0] - rspHs[1]), 128'd1);

`ifdef AES_DEC_ARBITER_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    tick();
    holdEngine = 1'b1;
    expectGrant(0);
    applyStimulus(0, 1, 1'b1);
    n = 0;
    while (expQ0.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("to_rsp_taken", 128'(expQ0.size()), 128'd0);
    checkOutput("to_latency", 128'(rspStart[0] - accCycle[0]), 128'd18);
    expectGrant(1);
    applyStimulus(1, 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkBit("to_no_grant_engine_busy", req1_ready, 1'b0);
    end
    engAbort = 1'b1;
    holdEngine = 1'b0;
    drain(100);
`else
    $display("[TB] engine stall without watchdog");
    tick();
    holdEngine = 1'b1;
    expectGrant(0);
    applyStimulus(0, 1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      checkBit("stall_no_rsp0", rsp0_valid, 1'b0);
    end
    holdEngine = 1'b0;
    drain(100);
`endif

    $display("[TB] reset in the middle of WAIT");
    tick();
    holdEngine = 1'b1;
    expectGrant(0);
    applyStimulus(0, 6, 1'b0);
    repeat (6) tick();
    checkOutput("midwait_job_taken", 128'(jobQ0.size()), 128'd0);
    doReset();
    expQ0.delete();
    holdEngine = 1'b0;
    tick();
    expectGrant(0);
    applyStimulus(0, 7, 1'b0);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_arbiter.md
AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, 8-bit: the maximum number of cycles to wait for the engine to become ready (used only with the timeout feature).
REQ-002 The block SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port reqN_valid (N=0,1), input, 1: requester N has a decipher job.
REQ-005 The block SHALL have port reqN_ready, output, 1: the arbiter accepts requester N's job this cycle.
REQ-006 The block SHALL have port reqN_block, input, 128: requester N's ciphertext block.
REQ-007 The block SHALL have port reqN_keylen, input, 1: requester N's key length (0 = AES-128, 1 = AES-256).
REQ-008 The block SHALL have port rspN_valid, output, 1: a result for requester N is available.
REQ-009 The block SHALL have port rspN_ready, input, 1: requester N takes the result.
REQ-010 The block SHALL have port rspN_block, output, 128: plaintext result for requester N.
REQ-011 The block SHALL have port rspN_err, output, 1: requester N's result is invalid because of a timeout.
REQ-012 The block SHALL have port eng_next, output, 1: single-cycle start pulse to the decipher engine.
REQ-013 The block SHALL have ports eng_keylen (output, 1) and eng_block (output, 128): the job's key length and block, presented to the engine.
REQ-014 The block SHALL have ports eng_ready (input, 1) and eng_new_block (input, 128): the engine's idle/done flag and its result.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 In IDLE with eng_ready=1, the block SHALL select a requester with reqN_valid=1 and assert only that requester's reqN_ready (combinational).
REQ-017 The block SHALL select requester N alone when only reqN_valid=1; when both are valid, it SHALL select the requester other than last_grant.
REQ-018 The block SHALL reset last_grant to 1, so requester 0 wins the first conflict.
REQ-019 In IDLE with eng_ready=0, the block SHALL deassert both reqN_ready.
REQ-020 On a valid&ready transfer, the block SHALL latch the block, keylen and grant index and move to ISSUE.
REQ-021 eng_block and eng_keylen SHALL come from the latched registers and stay stable from ISSUE until the next accepted job.
REQ-022 The block SHALL assert eng_next for exactly one cycle, in ISSUE, and then move to WAIT.
REQ-023 In WAIT, when eng_ready=1, the block SHALL capture eng_new_block into the result register and move to RESP.
REQ-024 In RESP, the block SHALL assert rspN_valid only for the granted N, holding rspN_block and rspN_err stable.
REQ-025 On rspN_ready=1 in RESP, the block SHALL update last_grant to the granted N and return to IDLE.
REQ-026 rspN_block of the non-granted requester SHALL read 0, and its rspN_valid SHALL be 0.
REQ-027 A reqN_valid arriving while the FSM is not in IDLE SHALL wait; the block SHALL never drop or reorder jobs within one requester.
REQ-028 Latency SHALL be: accept edge, then eng_next 1 cycle later, then rspN_valid 1 cycle after the first sampled eng_ready=1 in WAIT.
REQ-029 Back-to-back operation SHALL be possible: a RESP handshake and an IDLE grant may occur on consecutive cycles, with no extra idle cycle.

Reset
REQ-030 While reset_n=0, the block SHALL hold the FSM in IDLE, and hold the data, result and timeout registers at 0.
REQ-031 While reset_n=0, the outputs SHALL be: reqN_ready=0, rspN_valid=0, rspN_err=0, eng_next=0, eng_block=0, eng_keylen=0.
REQ-032 A reset during ISSUE, WAIT or RESP SHALL abandon the job with no response; the engine is reset by the same reset_n.

Configuration
REQ-033 Macro AES_DEC_ARBITER_TIMEOUT_EN SHALL enable an 8-bit watchdog counter that clears on entry to WAIT and increments each WAIT cycle with eng_ready=0.
REQ-034 With AES_DEC_ARBITER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL enter RESP with rspN_err=1 and rspN_block=0.
REQ-035 After such a timeout, the IDLE grant SHALL remain gated by eng_ready=1 (REQ-016).
REQ-036 Without AES_DEC_ARBITER_TIMEOUT_EN, there SHALL be no counter, rspN_err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-037 Single job: req0 block=69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, with an AES-128 engine model -> one eng_next pulse; rsp0_block=00112233445566778899aabbccddeeff; rsp0_err=0.
REQ-038 Simultaneous request after reset: req0 and req1 valid on the same cycle -> req0 granted first, req1 granted in the IDLE cycle after rsp0 handshake.
REQ-039 Fairness: both requesters valid continuously for 6 jobs -> grants alternate 0,1,0,1,0,1.
REQ-040 Backpressure: rsp1_ready held 0 for 20 cycles -> rsp1_valid and rsp1_block held stable; req0 not granted until the handshake.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=16): eng_ready held 0 after eng_next -> rspN_err=1 and rspN_block=0 after 16 WAIT cycles; no new grant until eng_ready=1.
REQ-042 Reset mid-WAIT: reset_n low for 2 cycles -> all outputs 0, FSM in IDLE, next request served normally.
